// File: rtl/pixel_serializer.sv
// pixel_serializer: parallel-in/serial-out pixel shifter with attribute decode.
// A holding register double-buffers one pixel/attribute byte pair. Each
// shift_en emits one registered RGBI pixel, MSB first.
// Optional feature macro: PIXSER_FLASH_EN (attr[7] with the flash input
// inverts the pixel bit). When undefined, flash and attr[7] are ignored.
module pixel_serializer #(
  parameter int PW = 8,
  parameter int CW = 3
) (
  input  logic          C,
  input  logic          R,
  input  logic [PW-1:0] pix_d,
  input  logic [7:0]    attr_d,
  input  logic          ld,
  input  logic          shift_en,
  input  logic          blank,
  input  logic [2:0]    border,
  input  logic          flash,
  output logic          req,
  output logic          ovr,
  output logic          q,
  output logic [3:0]    rgbi
);

  logic [PW-1:0] hold_pix, sh, sh_n;
  logic [7:0]    hold_attr, attr_s, attr_n;
  logic          full_h, act, act_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          boundary, xfer, b;
  logic [3:0]    col_n;
  logic          q_n;

  assign req = ~full_h;

  // Next shift/attr/count state plus the colour that state produces, so the
  // first bit of a byte reaches rgbi on the same edge as its transfer.
  always_comb begin
    sh_n     = sh;
    attr_n   = attr_s;
    cnt_n    = cnt;
    act_n    = act;
    boundary = ~act | (cnt == CW'(PW-1));
    xfer     = shift_en & boundary & full_h;
    if (shift_en) begin
      if (!boundary) begin
        sh_n  = {sh[PW-2:0], 1'b0};
        cnt_n = cnt + CW'(1);
      end else if (full_h) begin
        sh_n   = hold_pix;
        attr_n = hold_attr;
        cnt_n  = '0;
        act_n  = 1'b1;
      end else begin
        act_n  = 1'b0;  // underrun: border until the next transfer
      end
    end
`ifdef PIXSER_FLASH_EN
    b = sh_n[PW-1] ^ (attr_n[7] & flash);
`else
    b = sh_n[PW-1];
`endif
    if (blank)       col_n = 4'b0000;
    else if (!act_n) col_n = {border, 1'b0};
    else if (b)      col_n = {attr_n[2:0], attr_n[6]};
    else             col_n = {attr_n[5:3], attr_n[6]};
    q_n = act_n & b;
  end

`ifndef PIXSER_FLASH_EN
  // Flash path is compiled out; keep the input and attribute bit visibly sunk.
  logic unused_flash;
  assign unused_flash = flash ^ attr_n[7];
`endif

  // Holding register: accept a load when empty or when this edge empties it.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      hold_pix  <= '0;
      hold_attr <= '0;
      full_h    <= 1'b0;
      ovr       <= 1'b0;
    end else if (ld) begin
      if (!full_h || xfer) begin
        hold_pix  <= pix_d;
        hold_attr <= attr_d;
        full_h    <= 1'b1;
      end else begin
        ovr <= 1'b1;  // sticky until reset
      end
    end else if (xfer) begin
      full_h <= 1'b0;
    end
  end

  // Shift path and registered outputs; all hold between pixel enables.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      sh     <= '0;
      attr_s <= '0;
      cnt    <= '0;
      act    <= 1'b0;
      q      <= 1'b0;
      rgbi   <= 4'b0000;
    end else if (shift_en) begin
      sh     <= sh_n;
      attr_s <= attr_n;
      cnt    <= cnt_n;
      act    <= act_n;
      q      <= q_n;
      rgbi   <= col_n;
    end
  end

endmodule
